// File: rtl/led_scan_decoder_if.sv
// Scanned 7-segment bus and decoded-frame bundle for led_scan_decoder.
// master: scan source / frame consumer.  slave: the decoder.
// Optional order_err member exists when SCAN_ORDER_CHECK_EN is defined.
interface led_scan_decoder_if;
    logic [7:0]  LEDOUT;
    logic [3:0]  LEDSEL;
    logic [15:0] digit_hex;
    logic [3:0]  digit_blank;
    logic [3:0]  seg_err;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        scan_stall;
    logic        sel_err;
`ifdef SCAN_ORDER_CHECK_EN
    logic        order_err;

    modport master (
        output LEDOUT, LEDSEL,
        input  digit_hex, digit_blank, seg_err, dp,
        input  frame_valid, scan_stall, sel_err, order_err
    );
    modport slave (
        input  LEDOUT, LEDSEL,
        output digit_hex, digit_blank, seg_err, dp,
        output frame_valid, scan_stall, sel_err, order_err
    );
`else
    modport master (
        output LEDOUT, LEDSEL,
        input  digit_hex, digit_blank, seg_err, dp,
        input  frame_valid, scan_stall, sel_err
    );
    modport slave (
        input  LEDOUT, LEDSEL,
        output digit_hex, digit_blank, seg_err, dp,
        output frame_valid, scan_stall, sel_err
    );
`endif
endinterface

// File: rtl/led_scan_decoder.sv
// Rebuilds four hex digits from a scanned active-low LEDOUT/LEDSEL bus.
// Ports: clk50MHz, rst (sync, active-high), bus (led_scan_decoder_if.slave):
//   in LEDOUT[7:0], LEDSEL[3:0]; out digit_hex[15:0], digit_blank, seg_err,
//   dp, frame_valid (pulse), scan_stall (level), sel_err (sticky).
// Optional: SCAN_ORDER_CHECK_EN adds sticky bus.order_err (scan order check).
module led_scan_decoder #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic              clk50MHz,
    input logic              rst,
    led_scan_decoder_if.slave bus
);

    localparam int              CW      = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(SETTLE_CYC - 1);
    localparam logic [15:0]     TO_MAX  = 16'(TIMEOUT_CYC);

    // {blank, err, nibble}
    function automatic logic [5:0] dec7(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h40: r = 6'h00;
            7'h79: r = 6'h01;
            7'h24: r = 6'h02;
            7'h30: r = 6'h03;
            7'h19: r = 6'h04;
            7'h12: r = 6'h05;
            7'h02: r = 6'h06;
            7'h78: r = 6'h07;
            7'h00: r = 6'h08;
            7'h10: r = 6'h09;
            7'h08: r = 6'h0A;
            7'h03: r = 6'h0B;
            7'h46: r = 6'h0C;
            7'h21: r = 6'h0D;
            7'h06: r = 6'h0E;
            7'h0E: r = 6'h0F;
            7'h7F: r = 6'h20;
            default: r = 6'h10;
        endcase
        return r;
    endfunction

    logic [11:0]   prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [3:0]    seen_q, seen_d;
    logic          pend_q, pend_d;
    logic [15:0]   sh_hex_q, sh_hex_d;
    logic [3:0]    sh_blk_q, sh_blk_d;
    logic [3:0]    sh_err_q, sh_err_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [15:0]   hex_q;
    logic [3:0]    blk_q, err_q, dp_q;
    logic          fv_q;
    logic [15:0]   to_q, to_d;
    logic          sel_err_q;

    logic [3:0]    sel_n;
    logic          onehot, multi, same, stable, capture;
    logic [1:0]    idx;
    logic [5:0]    dcd;
    logic [3:0]    seen_new;

    always_comb begin
        sel_n  = ~bus.LEDSEL;
        multi  = (sel_n & (sel_n - 4'd1)) != 4'd0;
        onehot = (sel_n != 4'd0) && !multi;
        same   = {bus.LEDSEL, bus.LEDOUT} == prev_q;
        stable = same && onehot;
        // valid only when sel_n is one-hot
        idx    = {sel_n[3] | sel_n[2], sel_n[3] | sel_n[1]};
        dcd    = dec7(bus.LEDOUT[6:0]);

        cnt_d = '0;
        if (stable)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        // done blocks a second capture within one dwell
        capture = onehot && (cnt_d == CNT_MAX) && !(same && done_q);
        done_d  = capture || (stable && done_q);

        sh_hex_d = sh_hex_q;
        sh_blk_d = sh_blk_q;
        sh_err_d = sh_err_q;
        sh_dp_d  = sh_dp_q;
        seen_new = seen_q;
        if (capture) begin
            sh_hex_d[{idx, 2'b00} +: 4] = dcd[3:0];
            sh_blk_d[idx] = dcd[5];
            sh_err_d[idx] = dcd[4];
            sh_dp_d[idx]  = ~bus.LEDOUT[7];
            seen_new      = seen_q | (4'b0001 << idx);
        end

        // seen is cleared as the frame completes, so a capture on the
        // publish cycle already belongs to the next frame
        pend_d = capture && (seen_new == 4'hF);
        seen_d = pend_d ? 4'h0 : seen_new;

        to_d = to_q;
        if (capture)
            to_d = 16'd0;
        else if (to_q != TO_MAX)
            to_d = to_q + 16'd1;
    end

    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            seen_q    <= '0;
            pend_q    <= 1'b0;
            sh_hex_q  <= '0;
            sh_blk_q  <= '0;
            sh_err_q  <= '0;
            sh_dp_q   <= '0;
            hex_q     <= '0;
            blk_q     <= '0;
            err_q     <= '0;
            dp_q      <= '0;
            fv_q      <= 1'b0;
            to_q      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            prev_q    <= {bus.LEDSEL, bus.LEDOUT};
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            seen_q    <= seen_d;
            pend_q    <= pend_d;
            sh_hex_q  <= sh_hex_d;
            sh_blk_q  <= sh_blk_d;
            sh_err_q  <= sh_err_d;
            sh_dp_q   <= sh_dp_d;
            fv_q      <= pend_q;
            to_q      <= to_d;
            sel_err_q <= sel_err_q | multi;
            if (pend_q) begin
                hex_q <= sh_hex_q;
                blk_q <= sh_blk_q;
                err_q <= sh_err_q;
                dp_q  <= sh_dp_q;
            end
        end
    end

    assign bus.digit_hex   = hex_q;
    assign bus.digit_blank = blk_q;
    assign bus.seg_err     = err_q;
    assign bus.dp          = dp_q;
    assign bus.frame_valid = fv_q;
    assign bus.scan_stall  = (to_q == TO_MAX);
    assign bus.sel_err     = sel_err_q;

`ifdef SCAN_ORDER_CHECK_EN
    logic [1:0] last_q;
    logic       any_q;
    logic       ord_q;
    logic [1:0] exp_prev;

    assign exp_prev = idx - 2'd1;

    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            last_q <= '0;
            any_q  <= 1'b0;
            ord_q  <= 1'b0;
        end else if (capture) begin
            last_q <= idx;
            any_q  <= 1'b1;
            if (any_q && last_q != exp_prev && last_q != idx)
                ord_q <= 1'b1;
        end
    end

    assign bus.order_err = ord_q;
`endif

endmodule
